// File: rtl/multiexp_loader.sv
// Framed host stream loader for the multiexp engine: writes (scalar, x, y) triples into the
// scalar/point RAMs, then issues the core start handshake and waits for the core result.
module multiexp_loader #(
    parameter int unsigned DAT_BITS = 256,
    parameter int unsigned NUM_IN   = 128,
    parameter int unsigned A_BITS   = $clog2(NUM_IN)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DAT_BITS-1:0]   i_dat,
    input  logic                  i_val,
    input  logic                  i_sop,
    input  logic                  i_eop,
    output logic                  o_rdy,
    output logic                  o_scl_we,
    output logic [A_BITS-1:0]     o_scl_a,
    output logic [DAT_BITS-1:0]   o_scl_d,
    output logic                  o_pnt_we,
    output logic [A_BITS-1:0]     o_pnt_a,
    output logic [2*DAT_BITS-1:0] o_pnt_d,
    output logic                  o_core_val,
    input  logic                  i_core_rdy,
    input  logic                  i_core_done,
    output logic                  o_busy,
    output logic                  o_err
);

    typedef enum logic [2:0] {StIdle, StScl, StPx, StPy, StStart, StWait} state_e;

    localparam logic [A_BITS-1:0] LastIdx = A_BITS'(NUM_IN - 1);

    state_e                state_q, state_d;
    logic [A_BITS-1:0]     idx_q, idx_d;
    logic [DAT_BITS-1:0]   x_q, x_d;
    logic                  scl_we_q, scl_we_d;
    logic [A_BITS-1:0]     scl_a_q, scl_a_d;
    logic [DAT_BITS-1:0]   scl_d_q, scl_d_d;
    logic                  pnt_we_q, pnt_we_d;
    logic [A_BITS-1:0]     pnt_a_q, pnt_a_d;
    logic [2*DAT_BITS-1:0] pnt_d_q, pnt_d_d;
    logic                  err_q, err_d;
    logic                  accept;
    logic                  last_y;

    always_comb begin
        o_rdy = (state_q == StIdle) || (state_q == StScl) ||
                (state_q == StPx) || (state_q == StPy);
    end

    assign accept     = i_val & o_rdy;
    assign last_y     = (state_q == StPy) && (idx_q == LastIdx);
    assign o_core_val = (state_q == StStart);
    assign o_busy     = (state_q != StIdle);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        x_d      = x_q;
        scl_we_d = 1'b0;
        scl_a_d  = scl_a_q;
        scl_d_d  = scl_d_q;
        pnt_we_d = 1'b0;
        pnt_a_d  = pnt_a_q;
        pnt_d_d  = pnt_d_q;
        err_d    = 1'b0;

        unique case (state_q)
            StIdle, StScl, StPx, StPy: begin
                if (accept) begin
                    if (i_sop) begin
                        // A start-of-frame always restarts at scalar[0]; mid-frame it is an error.
                        err_d    = (state_q != StIdle);
                        scl_we_d = 1'b1;
                        scl_a_d  = '0;
                        scl_d_d  = i_dat;
                        idx_d    = '0;
                        state_d  = StPx;
                    end else begin
                        case (state_q)
                            StIdle: err_d = 1'b1;
                            StScl: begin
                                scl_we_d = 1'b1;
                                scl_a_d  = idx_q;
                                scl_d_d  = i_dat;
                                state_d  = StPx;
                            end
                            StPx: begin
                                x_d     = i_dat;
                                state_d = StPy;
                            end
                            StPy: begin
                                pnt_we_d = 1'b1;
                                pnt_a_d  = idx_q;
                                pnt_d_d  = {i_dat, x_q};
                                if (idx_q == LastIdx) begin
                                    state_d = i_eop ? StStart : StIdle;
                                    err_d   = !i_eop;
                                end else begin
                                    idx_d   = idx_q + 1'b1;
                                    state_d = StScl;
                                end
                            end
                            default: ;
                        endcase
                    end
                    // End-of-frame anywhere but the final y aborts; the beat's write still lands.
                    if (i_eop && !(last_y && !i_sop)) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StStart: if (i_core_rdy) state_d = StWait;
            StWait:  if (i_core_done) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            x_q      <= '0;
            scl_we_q <= 1'b0;
            scl_a_q  <= '0;
            scl_d_q  <= '0;
            pnt_we_q <= 1'b0;
            pnt_a_q  <= '0;
            pnt_d_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            x_q      <= x_d;
            scl_we_q <= scl_we_d;
            scl_a_q  <= scl_a_d;
            scl_d_q  <= scl_d_d;
            pnt_we_q <= pnt_we_d;
            pnt_a_q  <= pnt_a_d;
            pnt_d_q  <= pnt_d_d;
            err_q    <= err_d;
        end
    end

    assign o_scl_we = scl_we_q;
    assign o_scl_a  = scl_a_q;
    assign o_scl_d  = scl_d_q;
    assign o_pnt_we = pnt_we_q;
    assign o_pnt_a  = pnt_a_q;
    assign o_pnt_d  = pnt_d_q;
    assign o_err    = err_q;

endmodule

// File: tb/tb_multiexp_loader.sv
// Scoreboard bench for multiexp_loader: a NUM_IN=4 instance for directed framing cases and a
// NUM_IN=128 instance for a full frame with random valid gaps.
module tb_multiexp_loader;

    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst, val, sel, sop, eop, core_rdy, core_done;
    logic [DW-1:0] dat;
    logic val4, val128;

    logic          rdy4, scl_we4, pnt_we4, core_val4, busy4, err4;
    logic [1:0]    scl_a4, pnt_a4;
    logic [DW-1:0] scl_d4;
    logic [2*DW-1:0] pnt_d4;

    logic          rdy128, scl_we128, pnt_we128, core_val128, busy128, err128;
    logic [6:0]    scl_a128, pnt_a128;
    logic [DW-1:0] scl_d128;
    logic [2*DW-1:0] pnt_d128;

    logic          m_rdy, m_scl_we, m_pnt_we, m_core_val, m_busy, m_err;
    logic [6:0]    m_scl_a, m_pnt_a;
    logic [DW-1:0] m_scl_d;
    logic [2*DW-1:0] m_pnt_d;

    int total = 0;
    int bad = 0;
    int err_cnt = 0;
    int hs_cnt = 0;
    logic [127:0] q_scl[$];
    logic [127:0] q_pnt[$];
    logic [DW-1:0]   sh_scl[128];
    logic [2*DW-1:0] sh_pnt[128];

    always #5 clk = ~clk;

    assign val4   = val & !sel;
    assign val128 = val & sel;

    multiexp_loader #(.DAT_BITS(DW), .NUM_IN(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_dat(dat), .i_val(val4), .i_sop(sop), .i_eop(eop),
        .o_rdy(rdy4), .o_scl_we(scl_we4), .o_scl_a(scl_a4), .o_scl_d(scl_d4),
        .o_pnt_we(pnt_we4), .o_pnt_a(pnt_a4), .o_pnt_d(pnt_d4), .o_core_val(core_val4),
        .i_core_rdy(core_rdy), .i_core_done(core_done), .o_busy(busy4), .o_err(err4)
    );

    multiexp_loader #(.DAT_BITS(DW), .NUM_IN(128)) dut128 (
        .i_clk(clk), .i_rst(rst), .i_dat(dat), .i_val(val128), .i_sop(sop), .i_eop(eop),
        .o_rdy(rdy128), .o_scl_we(scl_we128), .o_scl_a(scl_a128), .o_scl_d(scl_d128),
        .o_pnt_we(pnt_we128), .o_pnt_a(pnt_a128), .o_pnt_d(pnt_d128),
        .o_core_val(core_val128), .i_core_rdy(core_rdy & sel), .i_core_done(core_done),
        .o_busy(busy128), .o_err(err128)
    );

    assign m_rdy      = sel ? rdy128 : rdy4;
    assign m_scl_we   = sel ? scl_we128 : scl_we4;
    assign m_scl_a    = sel ? scl_a128 : {5'b0, scl_a4};
    assign m_scl_d    = sel ? scl_d128 : scl_d4;
    assign m_pnt_we   = sel ? pnt_we128 : pnt_we4;
    assign m_pnt_a    = sel ? pnt_a128 : {5'b0, pnt_a4};
    assign m_pnt_d    = sel ? pnt_d128 : pnt_d4;
    assign m_core_val = sel ? core_val128 : core_val4;
    assign m_busy     = sel ? busy128 : busy4;
    assign m_err      = sel ? err128 : err4;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every RAM write must match the oldest expected write.
    always @(negedge clk) begin
        logic [127:0] e;
        if (!rst) begin
            if (m_scl_we) begin
                chk("scl_write_expected", 128'(q_scl.size() != 0), 128'(1));
                if (q_scl.size() != 0) begin
                    e = q_scl.pop_front();
                    chk("scl_write", 128'({m_scl_a, m_scl_d}), e);
                end
                sh_scl[m_scl_a] = m_scl_d;
            end
            if (m_pnt_we) begin
                chk("pnt_write_expected", 128'(q_pnt.size() != 0), 128'(1));
                if (q_pnt.size() != 0) begin
                    e = q_pnt.pop_front();
                    chk("pnt_write", 128'({m_pnt_a, m_pnt_d}), e);
                end
                sh_pnt[m_pnt_a] = m_pnt_d;
            end
            if (m_err) err_cnt++;
            if (m_core_val && core_rdy) hs_cnt++;
        end
    end

    task automatic push_scl(input int a, input logic [DW-1:0] d);
        q_scl.push_back(128'({7'(a), d}));
    endtask

    task automatic push_pnt(input int a, input logic [DW-1:0] x, input logic [DW-1:0] y);
        q_pnt.push_back(128'({7'(a), y, x}));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [DW-1:0] d, input bit s, input bit e, input int gapmax);
        int g;
        g = $urandom_range(gapmax, 0);
        repeat (g) step();
        chk("beat_rdy", 128'(m_rdy), 128'(1));
        val = 1'b1; dat = d; sop = s; eop = e;
        step();
        val = 1'b0; sop = 1'b0; eop = 1'b0;
    endtask

    task automatic triple(input int k, input logic [DW-1:0] s, input logic [DW-1:0] x,
                          input logic [DW-1:0] y, input bit first, input bit last,
                          input int gapmax);
        push_scl(k, s);
        push_pnt(k, x, y);
        beat(s, first, 1'b0, gapmax);
        beat(x, 1'b0, 1'b0, gapmax);
        beat(y, 1'b0, last, gapmax);
    endtask

    task automatic send_frame(input int n, input int gapmax, input bit rnd);
        for (int k = 0; k < n; k++) begin
            if (rnd) triple(k, $urandom, $urandom, $urandom, k == 0, k == n - 1, gapmax);
            else     triple(k, DW'(k + 1), DW'(16 + k), DW'(32 + k), k == 0, k == n - 1, gapmax);
        end
    endtask

    task automatic handshake(input string tag);
        for (int i = 0; i < 20 && !m_core_val; i++) step();
        chk({tag, "_core_val_up"}, 128'(m_core_val), 128'(1));
        core_rdy = 1'b1;
        step();
        core_rdy = 1'b0;
        chk({tag, "_wait_busy"}, 128'(m_busy), 128'(1));
        chk({tag, "_core_val_down"}, 128'(m_core_val), 128'(0));
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        chk({tag, "_idle_rdy"}, 128'(m_rdy), 128'(1));
        chk({tag, "_idle_busy"}, 128'(m_busy), 128'(0));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_scl_we"}, 128'(m_scl_we), 128'(0));
        chk({tag, "_pnt_we"}, 128'(m_pnt_we), 128'(0));
        chk({tag, "_core_val"}, 128'(m_core_val), 128'(0));
        chk({tag, "_err"}, 128'(m_err), 128'(0));
        chk({tag, "_busy"}, 128'(m_busy), 128'(0));
        chk({tag, "_scl_a_d"}, 128'({m_scl_a, m_scl_d}), 128'(0));
        chk({tag, "_pnt_a_d"}, 128'({m_pnt_a, m_pnt_d}), 128'(0));
    endtask

    task automatic check_queues(input string tag);
        chk({tag, "_scl_q_empty"}, 128'(q_scl.size()), 128'(0));
        chk({tag, "_pnt_q_empty"}, 128'(q_pnt.size()), 128'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; val = 1'b0; sel = 1'b0; sop = 1'b0; eop = 1'b0; dat = '0;
        core_rdy = 1'b0; core_done = 1'b0;
        repeat (3) step();
        check_reset("reset");
        rst = 1'b0;

        // Back-to-back good frame; start request one cycle after the last beat.
        send_frame(4, 0, 0);
        chk("t1_core_val", 128'(m_core_val), 128'(1));
        chk("t1_rdy_low", 128'(m_rdy), 128'(0));

        // Core not ready: request must hold.
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_core_val_hold", 128'(m_core_val), 128'(1));
            chk("t2_rdy_hold", 128'(m_rdy), 128'(0));
        end
        chk("t1_pnt2", 128'(sh_pnt[2]), 128'({32'h22, 32'h12}));
        chk("t1_scl3", 128'(sh_scl[3]), 128'(4));
        check_queues("t1");
        handshake("t2");
        chk("t2_hs_cnt", 128'(hs_cnt), 128'(1));
        chk("t2_err_cnt", 128'(err_cnt), 128'(0));

        // Early end-of-frame on beat 7 (scalar[2]).
        triple(0, 32'hA0, 32'hB0, 32'hC0, 1'b1, 1'b0, 0);
        triple(1, 32'hA1, 32'hB1, 32'hC1, 1'b0, 1'b0, 0);
        push_scl(2, 32'hA2);
        beat(32'hA2, 1'b0, 1'b1, 0);
        step();
        chk("t3_err_cnt", 128'(err_cnt), 128'(1));
        chk("t3_idle", 128'(m_busy), 128'(0));
        chk("t3_no_start", 128'(m_core_val), 128'(0));
        check_queues("t3");
        send_frame(4, 0, 1);
        handshake("t3");
        chk("t3_hs_cnt", 128'(hs_cnt), 128'(2));

        // Start-of-frame on beat 5 restarts the frame.
        push_scl(0, 32'h500);
        beat(32'h500, 1'b1, 1'b0, 0);
        beat(32'h501, 1'b0, 1'b0, 0);
        push_pnt(0, 32'h501, 32'h502);
        beat(32'h502, 1'b0, 1'b0, 0);
        push_scl(1, 32'h503);
        beat(32'h503, 1'b0, 1'b0, 0);
        push_scl(0, 32'h5A5);
        beat(32'h5A5, 1'b1, 1'b0, 0);
        push_pnt(0, 32'h610, 32'h620);
        beat(32'h610, 1'b0, 1'b0, 0);
        beat(32'h620, 1'b0, 1'b0, 0);
        for (int k = 1; k < 4; k++)
            triple(k, DW'(32'h700 + k), DW'(32'h710 + k), DW'(32'h720 + k), 1'b0, k == 3, 0);
        handshake("t4");
        chk("t4_err_cnt", 128'(err_cnt), 128'(2));
        chk("t4_hs_cnt", 128'(hs_cnt), 128'(3));
        chk("t4_scl0", 128'(sh_scl[0]), 128'(32'h5A5));
        check_queues("t4");

        // Full 128-entry frame with random valid gaps.
        sel = 1'b1;
        step();
        send_frame(128, 3, 1);
        handshake("t5");
        chk("t5_hs_cnt", 128'(hs_cnt), 128'(4));
        chk("t5_err_cnt", 128'(err_cnt), 128'(2));
        check_queues("t5");
        sel = 1'b0;
        step();

        // Reset while in PY at idx 2.
        triple(0, 32'hD0, 32'hE0, 32'hF0, 1'b1, 1'b0, 0);
        triple(1, 32'hD1, 32'hE1, 32'hF1, 1'b0, 1'b0, 0);
        push_scl(2, 32'hD2);
        beat(32'hD2, 1'b0, 1'b0, 0);
        beat(32'hE2, 1'b0, 1'b0, 0);
        rst = 1'b1;
        step();
        check_reset("t6_py");
        rst = 1'b0;
        check_queues("t6_py");

        // Reset while in START.
        send_frame(4, 0, 1);
        step();
        chk("t6_in_start", 128'(m_core_val), 128'(1));
        rst = 1'b1;
        step();
        check_reset("t6_start");
        rst = 1'b0;
        step();
        chk("t6_no_start", 128'(m_core_val), 128'(0));
        chk("t6_hs_cnt", 128'(hs_cnt), 128'(4));
        send_frame(4, 1, 1);
        handshake("t6");
        chk("t6_hs_after", 128'(hs_cnt), 128'(5));
        chk("t6_err_cnt", 128'(err_cnt), 128'(2));
        check_queues("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multiexp_loader.md
Name: multiexp_loader

Overview:
Write-side front end for the multiexp engine. Accepts a framed host stream of (scalar, point.x, point.y) triples and writes them into the scalar and point RAMs that the multiexp core reads. After a complete, well-formed frame it issues the core start handshake. It then holds off new frames until the core reports its result valid.

Parameters:
DAT_BITS, 256, bits per scalar and per point coordinate; also the stream beat width
NUM_IN, 128, triples per frame; equals the RAM depth
A_BITS, $clog2(NUM_IN), RAM address width

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_dat  in  DAT_BITS  stream beat data
i_val  in  1  beat valid
i_sop  in  1  first beat of frame
i_eop  in  1  last beat of frame
o_rdy  out  1  loader can accept a beat
o_scl_we  out  1  scalar RAM write enable
o_scl_a  out  A_BITS  scalar RAM address
o_scl_d  out  DAT_BITS  scalar RAM write data
o_pnt_we  out  1  point RAM write enable
o_pnt_a  out  A_BITS  point RAM address
o_pnt_d  out  2*DAT_BITS  point RAM write data, {y,x}
o_core_val  out  1  start request to core (drives core i_val)
i_core_rdy  in  1  core accepts start (core o_rdy)
i_core_done  in  1  core result valid (core o_val)
o_busy  out  1  high in every state except IDLE
o_err  out  1  one-cycle pulse on a framing error

Behaviour:
- Beat accepted when i_val & o_rdy. Frame = 3*NUM_IN beats, ordered per index k: scalar[k], x[k], y[k], for k = 0..NUM_IN-1.
- States: IDLE, SCL, PX, PY, START, WAIT. o_rdy=1 in IDLE/SCL/PX/PY, 0 in START/WAIT.
- IDLE: an accepted beat with i_sop is treated as scalar[0] and moves to PX. An accepted beat without i_sop is dropped and pulses o_err.
- SCL: accepted beat is scalar[idx]; next state PX.
- Scalar write: registered. o_scl_we=1 for exactly one cycle, on the cycle after acceptance, with o_scl_a=idx and o_scl_d=beat.
- PX: accepted beat is latched into x_reg; no RAM write; next state PY.
- PY: accepted beat produces a registered write on the next cycle: o_pnt_we=1, o_pnt_a=idx, o_pnt_d={beat,x_reg}.
  - idx==NUM_IN-1 with i_eop=1: go to START.
  - idx==NUM_IN-1 with i_eop=0: pulse o_err, go to IDLE. The RAM write still occurs.
  - otherwise: idx++ and go to SCL.
- i_eop on any accepted beat other than the final y: pulse o_err and go to IDLE. That beat's RAM write, if any, still occurs. No start is issued.
- i_sop on an accepted beat in SCL/PX/PY: pulse o_err and restart the frame. The beat becomes scalar[0], idx=0, next state PX.
- START: o_core_val=1, held until a cycle with i_core_rdy=1, then go to WAIT. o_core_val must not drop before handshake.
- WAIT: on i_core_done=1, go to IDLE.
- i_core_done in any other state is ignored.
- Every frame overwrites all NUM_IN RAM entries.
- Reset, including mid-frame or mid-START: state=IDLE, idx=0, x_reg=0, and o_scl_we, o_pnt_we, o_core_val, o_err, o_busy all 0. Addresses and data outputs reset to 0. Reset itself never generates a start.
- Single-cycle throughput: a beat can be accepted every cycle. Stalls (i_val=0) in any receive state hold state and idx.

Test Plan:
- NUM_IN=4, 12 back-to-back beats, scalar[k]=k+1, x[k]=0x10+k, y[k]=0x20+k, sop/eop correct -> 4 scalar writes and 4 point writes; pnt entry 2 = {0x22,0x12}; o_core_val rises 1 cycle after the last beat.
- Hold i_core_rdy=0 for 5 cycles after o_core_val rises -> o_core_val stays high and o_rdy stays 0. Raise i_core_rdy -> enter WAIT. Pulse i_core_done -> o_rdy=1 and o_busy=0 the next cycle.
- i_eop on beat 7 of 12 -> o_err pulses once, no o_core_val, loader in IDLE. A following good frame completes normally.
- i_sop asserted on beat 5 -> o_err pulses and the frame restarts. The next 11 beats complete it, and scl entry 0 = beat 5 data.
- Random i_val gaps across a full 3*NUM_IN-beat frame at NUM_IN=128 -> RAM contents match the reference model and exactly one start handshake occurs.
- Assert i_rst while in PY at idx=2, then while in START -> all outputs 0 the next cycle, no start, and a subsequent frame loads correctly.
